ascon_inv_permutation: RTL

Iterative inverse of the Ascon permutation p^n (NIST SP 800-232 Sec 3), computing one inverse round per clock behind a valid/ready handshake. It is the counterpart of the forward permutation datapath built from substitution_layer. It serves as a golden inverse for round-trip verification of the forward core and as a state-recovery primitive in debug builds. It sits beside the forward permutation and operates on the shared ascon_state_t.

---
 rtl/ascon_pkg.sv | 64 ++++++
 rtl/inv_substitution_layer.sv | 22 ++
 rtl/ascon_inv_permutation.sv | 103 ++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// Shared Ascon state type, inverse S-box, linear-layer rotations and round helpers.
package ascon_pkg;

   localparam int unsigned WORD_W     = 64;
   localparam int unsigned NUM_WORDS  = 5;
   localparam int unsigned ROUNDS_W   = 4;
   localparam int unsigned MAX_ROUNDS = 12;

   typedef logic [NUM_WORDS-1:0][WORD_W-1:0] ascon_state_t;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} inv_fsm_t;

   // Column value {S0,S1,S2,S3,S4} (S0 = MSB) -> preimage under the forward S-box.
   localparam logic [4:0] SBOX_INV [32] = '{
      5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
      5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
      5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
      5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
   };

   localparam int unsigned ROT_A [NUM_WORDS] = '{19, 61, 1, 10, 7};
   localparam int unsigned ROT_B [NUM_WORDS] = '{28, 39, 6, 17, 41};

   function automatic logic [7:0] round_const(input logic [ROUNDS_W-1:0] r);
      return {4'(4'd15 - r), r};
   endfunction

   function automatic logic [WORD_W-1:0] rotr64(input logic [WORD_W-1:0] x,
                                                input int unsigned amt);
      int unsigned m;
      m = amt % WORD_W;
      return (x >> m) | (x << ((WORD_W - m) % WORD_W));
   endfunction

   // Sigma^-1 = Sigma^63 = product of Sigma^(2^j), j = 0..5, each a fixed rotation pair.
   function automatic logic [WORD_W-1:0] inv_sigma(input logic [WORD_W-1:0] x,
                                                   input int unsigned a,
                                                   input int unsigned b);
      logic [WORD_W-1:0] y;
      y = x;
      for (int j = 0; j < 6; j++) begin
         y = y ^ rotr64(y, (a << j) % WORD_W) ^ rotr64(y, (b << j) % WORD_W);
      end
      return y;
   endfunction

   function automatic ascon_state_t inv_linear_layer(input ascon_state_t s);
      ascon_state_t r;
      r = s;
      for (int k = 0; k < int'(NUM_WORDS); k++) begin
         r[k] = inv_sigma(s[k], ROT_A[k], ROT_B[k]);
      end
      return r;
   endfunction

   function automatic ascon_state_t add_round_const(input ascon_state_t s,
                                                    input logic [ROUNDS_W-1:0] r);
      ascon_state_t t;
      t = s;
      t[2][7:0] = s[2][7:0] ^ round_const(r);
      return t;
   endfunction

endpackage

// File: rtl/inv_substitution_layer.sv
// Combinational inverse Ascon S-box applied to all 64 five-bit columns.
module inv_substitution_layer
   import ascon_pkg::*;
(
   input  ascon_state_t state_array_i,
   output ascon_state_t state_array_o
);

   for (genvar j = 0; j < int'(WORD_W); j++) begin : g_col
      logic [4:0] col;
      logic [4:0] res;
      assign col = {state_array_i[0][j], state_array_i[1][j], state_array_i[2][j],
                    state_array_i[3][j], state_array_i[4][j]};
      assign res = SBOX_INV[col];
      assign state_array_o[0][j] = res[4];
      assign state_array_o[1][j] = res[3];
      assign state_array_o[2][j] = res[2];
      assign state_array_o[3][j] = res[1];
      assign state_array_o[4][j] = res[0];
   end

endmodule

// File: rtl/ascon_inv_permutation.sv
// Iterative inverse Ascon permutation, one inverse round per clock behind valid/ready.
// Define ASCON_INV_ROUNDS2_EN to invert two rounds per RUN cycle.
module ascon_inv_permutation
   import ascon_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                valid_i,
   output logic                ready_o,
   input  logic [ROUNDS_W-1:0] rounds_i,
   input  ascon_state_t        state_array_i,
   output logic                valid_o,
   input  logic                ready_i,
   output ascon_state_t        state_array_o
);

   inv_fsm_t            fsm;
   ascon_state_t        work;
   logic [ROUNDS_W-1:0] cnt;
   logic [ROUNDS_W-1:0] rnd;
   logic [ROUNDS_W-1:0] n_clamped;

   ascon_state_t lin1, sb1, round1;

   assign n_clamped = (rounds_i > ROUNDS_W'(MAX_ROUNDS)) ? ROUNDS_W'(MAX_ROUNDS) : rounds_i;

   // Inverse round for index rnd: linear layer, S-box, then constant.
   assign lin1   = inv_linear_layer(work);
   inv_substitution_layer u_sbox1 (.state_array_i(lin1), .state_array_o(sb1));
   assign round1 = add_round_const(sb1, rnd);

`ifdef ASCON_INV_ROUNDS2_EN
   ascon_state_t lin2, sb2, round2;
   assign lin2   = inv_linear_layer(round1);
   inv_substitution_layer u_sbox2 (.state_array_i(lin2), .state_array_o(sb2));
   assign round2 = add_round_const(sb2, rnd - ROUNDS_W'(1));
`endif

   assign state_array_o = work;

   // The first inverted round is always index 11, whatever n is.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fsm     <= ST_IDLE;
         work    <= '0;
         cnt     <= '0;
         rnd     <= '0;
         valid_o <= 1'b0;
         ready_o <= 1'b1;
      end else begin
         case (fsm)
            ST_IDLE: begin
               if (valid_i && ready_o) begin
                  work    <= state_array_i;
                  cnt     <= n_clamped;
                  rnd     <= ROUNDS_W'(MAX_ROUNDS - 1);
                  ready_o <= 1'b0;
                  fsm     <= (n_clamped == '0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
`ifdef ASCON_INV_ROUNDS2_EN
               if (cnt >= ROUNDS_W'(2)) begin
                  work <= round2;
                  cnt  <= cnt - ROUNDS_W'(2);
                  rnd  <= rnd - ROUNDS_W'(2);
                  if (cnt == ROUNDS_W'(2)) begin
                     fsm     <= ST_DONE;
                     valid_o <= 1'b1;
                  end
               end else begin
                  work    <= round1;
                  cnt     <= cnt - ROUNDS_W'(1);
                  rnd     <= rnd - ROUNDS_W'(1);
                  fsm     <= ST_DONE;
                  valid_o <= 1'b1;
               end
`else
               work <= round1;
               cnt  <= cnt - ROUNDS_W'(1);
               rnd  <= rnd - ROUNDS_W'(1);
               if (cnt == ROUNDS_W'(1)) begin
                  fsm     <= ST_DONE;
                  valid_o <= 1'b1;
               end
`endif
            end
            ST_DONE: begin
               // n = 0 enters DONE straight from IDLE; valid_o follows one edge later.
               if (!valid_o) begin
                  valid_o <= 1'b1;
               end else if (ready_i) begin
                  valid_o <= 1'b0;
                  ready_o <= 1'b1;
                  fsm     <= ST_IDLE;
               end
            end
            default: fsm <= ST_IDLE;
         endcase
      end
   end

endmodule
